fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives the word address into the memory.
- Captures the returned instruction into the IF/ID pipeline register, which the decode stage consumes.
- Handles decode-stage stalls, branch/jump redirects with flush, and a sticky fetch-fault halt on misaligned or out-of-range PCs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 2048, number of valid 32-bit words in instruction memory; byte addresses at or above IMEM_WORDS*4 are out of range.
- NOP_INSTR, 32'h0000_0013, instruction placed in the IF/ID register on reset and flush (addi x0,x0,0).

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- imem_addr  output  32  Byte address to instruction memory; equals pc_q, combinational from the register.
- imem_instr  input  32  Instruction word returned combinationally by instruction memory for imem_addr.
- stall  input  1  Decode/hazard stall; hold PC and IF/ID contents.
- redirect_valid  input  1  Branch/jump taken; load redirect_pc and flush.
- redirect_pc  input  32  Redirect target byte address.
- ifid_valid  output  1  IF/ID register holds a real instruction.
- ifid_instr  output  32  Fetched instruction.
- ifid_pc  output  32  PC of ifid_instr.
- ifid_pc_plus4  output  32  ifid_pc + 4, modulo 2^32.
- fetch_fault  output  1  Sticky fault; fetch halted until reset.
- fetch_count  output  32  Count of valid instructions loaded into IF/ID; wraps.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - pc_q=RESET_PC; state=BOOT.
  - ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=4.
  - fetch_fault=0, fetch_count=0.
- States: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after reset deasserts; PC held, ifid_valid=0.
  - Next state is RUN, or HALT if RESET_PC is misaligned or out of range.
- RUN, priority order redirect_valid > stall > normal advance:
  - redirect_valid=1:
    - If redirect_pc is aligned and in range: pc_q<=redirect_pc; IF/ID flushed (ifid_valid<=0, ifid_instr<=NOP_INSTR); fetch_count unchanged.
    - If redirect_pc[1:0]!=0 or redirect_pc>=IMEM_WORDS*4: pc_q unchanged, IF/ID flushed, fetch_fault<=1, state<=HALT.
    - redirect wins over a simultaneous stall.
  - stall=1 (no redirect): pc_q, all ifid_* outputs and fetch_count hold their values.
  - Normal advance:
    - ifid_instr<=imem_instr, ifid_pc<=pc_q, ifid_pc_plus4<=pc_q+4, ifid_valid<=1, fetch_count<=fetch_count+1.
    - Next PC is pc_q+4.
    - If pc_q+4 >= IMEM_WORDS*4 (including 32-bit wrap to a lower value that lies out of range), the current instruction is still delivered. pc_q<=pc_q+4, then fetch_fault<=1 and state<=HALT on that same edge; no fetch from the out-of-range address occurs.
- HALT:
  - pc_q frozen; ifid_valid<=0 on the first HALT cycle and held 0.
  - fetch_fault stays 1; stall and redirect ignored; exit only via rst.
- Latency: instruction at pc_q appears on ifid_* one edge after pc_q is presented. The first valid instruction appears on the second rising edge after rst deasserts.
- Steady state without stalls or redirects delivers one valid instruction per cycle.
- Arithmetic: all PC adds are 32-bit unsigned modulo 2^32; fetch_count wraps 0xFFFF_FFFF->0.
- imem_addr is always pc_q, including during stall and HALT.

Test Plan:
- Reset then run free with memory words 0x00A00093, 0x00100113 at 0x0, 0x4 -> imem_addr 0,0,4,8; ifid_valid rises on edge 2 with ifid_instr=0x00A00093, ifid_pc=0; next edge 0x00100113, ifid_pc=4, ifid_pc_plus4=8; fetch_count=2.
- stall high for 3 cycles at pc_q=0x8 -> imem_addr stays 0x8, ifid_pc stays 0x4, fetch_count unchanged; the next cycle after release loads ifid_pc=0x8.
- redirect_valid with redirect_pc=0x40 while stall=1 at pc_q=0x10 -> next cycle ifid_valid=0, ifid_instr=0x00000013, imem_addr=0x40; the following cycle ifid_pc=0x40, valid=1.
- redirect_pc=0x42 -> fetch_fault=1 next edge, ifid_valid=0, imem_addr frozen at the pre-redirect value; later redirects and stalls ignored; rst clears everything to the reset values.
- Sequential run reaching pc_q=0x1FFC (IMEM_WORDS=2048) -> instruction at 0x1FFC delivered valid, pc_q becomes 0x2000, fetch_fault=1, ifid_valid=0 thereafter.
- Assert rst for one cycle mid-redirect at pc_q=0x100 -> outputs take reset values immediately (asynchronously), BOOT repeats, fetch resumes from RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, decode-side controls and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output ifid_valid,
        output ifid_instr,
        output ifid_pc,
        output ifid_pc_plus4,
        output fetch_fault,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  ifid_valid,
        input  ifid_instr,
        input  ifid_pc,
        input  ifid_pc_plus4,
        input  fetch_fault,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, feeds the combinational instruction memory
// and loads the IF/ID register; handles stall, redirect/flush and a sticky fetch fault.
//
// state | meaning
// BOOT  | single cycle after reset, PC held, nothing fetched yet
// RUN   | fetching one instruction per cycle unless stalled or redirected
// HALT  | fetch fault seen, everything frozen until reset
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 2048,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // 33 bits so the limit check also covers PCs that wrapped past 2^32
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({1'b0, a} < IMEM_LIMIT);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= BOOT;
            pc_q            <= RESET_PC;
            ifid_valid_q    <= 1'b0;
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_q       <= 32'h0000_0000;
            ifid_pc_plus4_q <= 32'h0000_0004;
            fetch_fault_q   <= 1'b0;
            fetch_count_q   <= 32'h0000_0000;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            fetch_fault_q   <= fetch_fault_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_valid_d    = ifid_valid_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        fetch_fault_d   = fetch_fault_q;
        fetch_count_d   = fetch_count_q;

        unique case (state_q)
            BOOT: begin
                ifid_valid_d = 1'b0;
                if (addr_ok(RESET_PC)) begin
                    state_d = RUN;
                end else begin
                    state_d       = HALT;
                    fetch_fault_d = 1'b1;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    if (addr_ok(bus.redirect_pc)) begin
                        pc_d = bus.redirect_pc;
                    end else begin
                        fetch_fault_d = 1'b1;
                        state_d       = HALT;
                    end
                end else if (!bus.stall) begin
                    ifid_valid_d    = 1'b1;
                    ifid_instr_d    = bus.imem_instr;
                    ifid_pc_d       = pc_q;
                    ifid_pc_plus4_d = pc_plus4;
                    fetch_count_d   = fetch_count_q + 32'd1;
                    pc_d            = pc_plus4;
                    // last word delivered; the out-of-range PC is never fetched
                    if (!addr_ok(pc_plus4)) begin
                        fetch_fault_d = 1'b1;
                        state_d       = HALT;
                    end
                end
            end
            HALT: begin
                ifid_valid_d  = 1'b0;
                fetch_fault_d = 1'b1;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign bus.imem_addr     = pc_q;
    assign bus.ifid_valid    = ifid_valid_q;
    assign bus.ifid_instr    = ifid_instr_q;
    assign bus.ifid_pc       = ifid_pc_q;
    assign bus.ifid_pc_plus4 = ifid_pc_plus4_q;
    assign bus.fetch_fault   = fetch_fault_q;
    assign bus.fetch_count   = fetch_count_q;

endmodule
